// File: rtl/tft_pkg.sv
// Shared definitions for the TFT receive-side decoder: command codes, decoder
// states and the power-on address window.
package tft_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   // Full 16-bit defaults; narrower coordinate builds take the low bits.
   localparam logic [15:0] DEF_XS = 16'd0;
   localparam logic [15:0] DEF_XE = 16'd239;
   localparam logic [15:0] DEF_YS = 16'd0;
   localparam logic [15:0] DEF_YE = 16'd319;

   typedef enum logic [2:0] {
      StIdle,
      StCaset,
      StPaset,
      StRamwr,
      StSkip
   } dec_state_e;

   function automatic dec_state_e cmd_to_state(input logic [7:0] code);
      dec_state_e st;
      case (code)
         CMD_CASET: st = StCaset;
         CMD_PASET: st = StPaset;
         CMD_RAMWR: st = StRamwr;
         default:   st = StSkip;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/tft_rx_decoder_if.sv
// Pin-side SPI inputs and decoded outputs of the TFT receive decoder.
// master drives the SPI pins and observes results; slave is the decoder.
interface tft_rx_decoder_if #(
   parameter int unsigned COORD_W = 9
);

   logic               tft_clk;
   logic               tft_mosi;
   logic               tft_dc;
   logic               tft_cs;
   logic               byte_valid;
   logic [7:0]         byte_data;
   logic               byte_dc;
   logic               cmd_valid;
   logic [7:0]         cmd_code;
   logic               pix_valid;
   logic [COORD_W-1:0] pix_x;
   logic [COORD_W-1:0] pix_y;
   logic [15:0]        pix_data;
   logic [COORD_W-1:0] win_xs;
   logic [COORD_W-1:0] win_xe;
   logic [COORD_W-1:0] win_ys;
   logic [COORD_W-1:0] win_ye;

   modport master (
      output tft_clk, tft_mosi, tft_dc, tft_cs,
      input  byte_valid, byte_data, byte_dc, cmd_valid, cmd_code,
      input  pix_valid, pix_x, pix_y, pix_data,
      input  win_xs, win_xe, win_ys, win_ye
   );

   modport slave (
      input  tft_clk, tft_mosi, tft_dc, tft_cs,
      output byte_valid, byte_data, byte_dc, cmd_valid, cmd_code,
      output pix_valid, pix_x, pix_y, pix_data,
      output win_xs, win_xe, win_ys, win_ye
   );

endinterface

// File: rtl/spi_byte_rx.sv
// Oversampled SPI byte receiver: synchronizers, tft_clk rising-edge detect, MSB-first shifter.
// Chip select is honoured only when TFT_RX_CS_EN is defined.
module spi_byte_rx #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tft_clk,
   input  logic       tft_mosi,
   input  logic       tft_dc,
   input  logic       tft_cs,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_dc
);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] dc_sync;
   logic                   clk_prev;
   logic [6:0]             shift;
   logic [2:0]             bit_cnt;
   logic                   selected;
   logic                   rise;

   assign rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;

`ifdef TFT_RX_CS_EN
   logic [SYNC_STAGES-1:0] cs_sync;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cs_sync <= '0;
      end else begin
         cs_sync <= {cs_sync[SYNC_STAGES-2:0], tft_cs};
      end
   end

   assign selected = ~cs_sync[SYNC_STAGES-1];
`else
   logic unused_cs;
   assign unused_cs = tft_cs;
   assign selected  = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_sync   <= '0;
         mosi_sync  <= '0;
         dc_sync    <= '0;
         clk_prev   <= 1'b0;
         shift      <= '0;
         bit_cnt    <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         byte_dc    <= 1'b0;
      end else begin
         clk_sync   <= {clk_sync[SYNC_STAGES-2:0], tft_clk};
         mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], tft_mosi};
         dc_sync    <= {dc_sync[SYNC_STAGES-2:0], tft_dc};
         clk_prev   <= clk_sync[SYNC_STAGES-1];
         byte_valid <= 1'b0;
         if (!selected) begin
            // Deselect throws away any partially assembled byte.
            shift   <= '0;
            bit_cnt <= '0;
         end else if (rise) begin
            shift   <= {shift[5:0], mosi_sync[SYNC_STAGES-1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_data  <= {shift, mosi_sync[SYNC_STAGES-1]};
               byte_dc    <= dc_sync[SYNC_STAGES-1];
               byte_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tft_rx_decoder.sv
// TFT display command decoder: tracks CASET/PASET address window and turns RAMWR data
// into addressed RGB565 pixel writes. Optional macro TFT_RX_CS_EN enables chip select.
module tft_rx_decoder
   import tft_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned COORD_W     = 9
) (
   input logic              clk,
   input logic              rst,
   tft_rx_decoder_if.slave  bus
);

   logic               rx_valid;
   logic [7:0]         rx_data;
   logic               rx_dc;

   dec_state_e         state;
   logic [1:0]         param_idx;
   logic               param_done;
   logic [7:0]         param_hi;
   logic               half;
   logic [7:0]         pix_hi;
   logic [7:0]         cmd_q;
   logic [COORD_W-1:0] cur_x, cur_y, x_next, y_next, coord;
   logic [COORD_W-1:0] win_xs, win_xe, win_ys, win_ye;
   logic               pix_valid;
   logic [COORD_W-1:0] pix_x, pix_y;
   logic [15:0]        pix_data;

   spi_byte_rx #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .tft_clk    (bus.tft_clk),
      .tft_mosi   (bus.tft_mosi),
      .tft_dc     (bus.tft_dc),
      .tft_cs     (bus.tft_cs),
      .byte_valid (rx_valid),
      .byte_data  (rx_data),
      .byte_dc    (rx_dc)
   );

   assign coord = COORD_W'({param_hi, rx_data});

   always_comb begin
      x_next = cur_x + COORD_W'(1);
      y_next = cur_y;
      if (cur_x == win_xe) begin
         x_next = win_xs;
         y_next = (cur_y == win_ye) ? win_ys : cur_y + COORD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= StIdle;
         param_idx  <= '0;
         param_done <= 1'b0;
         param_hi   <= '0;
         half       <= 1'b0;
         pix_hi     <= '0;
         cmd_q      <= '0;
         cur_x      <= '0;
         cur_y      <= '0;
         win_xs     <= DEF_XS[COORD_W-1:0];
         win_xe     <= DEF_XE[COORD_W-1:0];
         win_ys     <= DEF_YS[COORD_W-1:0];
         win_ye     <= DEF_YE[COORD_W-1:0];
         pix_valid  <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_data   <= '0;
      end else begin
         pix_valid <= 1'b0;
         if (rx_valid && !rx_dc) begin
            // Any command restarts decoding; a pending hi half-pixel is dropped.
            state      <= cmd_to_state(rx_data);
            cmd_q      <= rx_data;
            param_idx  <= '0;
            param_done <= 1'b0;
            half       <= 1'b0;
            cur_x      <= win_xs;
            cur_y      <= win_ys;
         end else if (rx_valid) begin
            case (state)
               StCaset, StPaset: begin
                  if (!param_done) begin
                     param_idx <= param_idx + 2'd1;
                     if (param_idx == 2'd3) param_done <= 1'b1;
                     case (param_idx)
                        2'd0, 2'd2: param_hi <= rx_data;
                        2'd1: begin
                           if (state == StCaset) win_xs <= coord;
                           else                  win_ys <= coord;
                        end
                        2'd3: begin
                           if (state == StCaset) win_xe <= coord;
                           else                  win_ye <= coord;
                        end
                     endcase
                  end
               end
               StRamwr: begin
                  if (!half) begin
                     pix_hi <= rx_data;
                     half   <= 1'b1;
                  end else begin
                     half      <= 1'b0;
                     pix_valid <= 1'b1;
                     pix_x     <= cur_x;
                     pix_y     <= cur_y;
                     pix_data  <= {pix_hi, rx_data};
                     cur_x     <= x_next;
                     cur_y     <= y_next;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.byte_valid = rx_valid;
   assign bus.byte_data  = rx_data;
   assign bus.byte_dc    = rx_dc;
   assign bus.cmd_valid  = rx_valid & ~rx_dc;
   // Present the new code in the same cycle as cmd_valid, then hold it.
   assign bus.cmd_code   = (rx_valid && !rx_dc) ? rx_data : cmd_q;
   assign bus.pix_valid  = pix_valid;
   assign bus.pix_x      = pix_x;
   assign bus.pix_y      = pix_y;
   assign bus.pix_data   = pix_data;
   assign bus.win_xs     = win_xs;
   assign bus.win_xe     = win_xe;
   assign bus.win_ys     = win_ys;
   assign bus.win_ye     = win_ye;

endmodule

// File: doc/tft_rx_decoder.md
# tft_rx_decoder

Receive-side model of the TFT display controller. Samples the four-wire SPI stream (tft_clk, tft_mosi, tft_dc, tft_cs) on the system clock, reassembles bytes, and decodes the display command set:
- CASET 0x2A and PASET 0x2B set the address window.
- RAMWR 0x2C pixel data becomes addressed RGB565 pixel writes.

It sits on the analyzer pins beside the SPI transmitter. It gives on-chip checking of everything the init, scene and player drawers send, and it feeds a frame-buffer shadow.

## Interface
- SYNC_STAGES, 2, flip-flops per input synchronizer, minimum 2.
- COORD_W, 9, width of the x/y coordinate and window registers.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- tft_clk  in  1  SPI clock; data sampled on its rising edge.
- tft_mosi  in  1  SPI data, MSB first.
- tft_dc  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- tft_cs  in  1  chip select, active-low.
- byte_valid  out  1  one-cycle pulse per received byte.
- byte_data  out  8  received byte, held until the next byte.
- byte_dc  out  1  dc value of byte_data.
- cmd_valid  out  1  one-cycle pulse for any command byte (dc=0).
- cmd_code  out  8  last command byte.
- pix_valid  out  1  one-cycle pulse per completed pixel.
- pix_x, pix_y  out  COORD_W  coordinate of the pixel being written.
- pix_data  out  16  RGB565 value, first byte in [15:8].
- win_xs, win_xe, win_ys, win_ye  out  COORD_W  current address window.

## Operation
- **Front end.**
  - Each SPI input passes through a SYNC_STAGES synchronizer.
  - Rising-edge detection on synchronized tft_clk.
  - On each edge, mosi shifts into an 8-bit register and a 3-bit counter increments.
  - On the edge where the counter wraps 7→0: the byte is latched, dc is latched, and byte_valid pulses.
- **Decoder FSM** states: IDLE, CASET, PASET, RAMWR, SKIP.
  - Any dc=0 byte forces the next state regardless of the current state. 0x2A→CASET, 0x2B→PASET, 0x2C→RAMWR, anything else→SKIP.
  - A 2-bit parameter index and a pixel-half flag both clear on every command.
- **CASET / PASET.**
  - Data bytes in order: start hi, start lo, end hi, end lo. Each 16-bit value is truncated to COORD_W bits.
  - The window register updates as each value completes (after its lo byte).
  - Bytes beyond the fourth are ignored, and the state stays put until the next command.
- **RAMWR.**
  - On entry: x←win_xs, y←win_ys.
  - Data bytes alternate between the hi half and the lo half. On the lo half, pix_valid pulses with the current x/y.
  - Cursor advance after a pixel:
    - x==win_xe: x←win_xs and y advances.
    - Otherwise x←x+1, modulo 2^COORD_W.
  - y advances the same way: y==win_ye wraps to win_ys.
  - A window with xs>xe is not rejected. x counts up modulo 2^COORD_W until it equals xe.
- **IDLE / SKIP:** data bytes produce only byte_valid.

## Timing
- Reset values:
  - All pulse outputs 0; byte_data, byte_dc, cmd_code, pix_* all 0.
  - Window: xs=0, xe=239, ys=0, ye=319. With COORD_W<9, the defaults are truncated.
  - FSM in IDLE; bit counter 0; synchronizers cleared.
- Reset mid-byte or mid-pixel discards the partial byte and the partial pixel.
- byte_valid asserts SYNC_STAGES+1 clk cycles after the 8th tft_clk rising edge reaches the pin.
- cmd_valid is coincident with byte_valid for a command byte.
- pix_valid, and the window register update, come 1 cycle after the completing byte_valid.
- pix_x/pix_y/pix_data are valid only while pix_valid=1.
- tft_clk high and low phases must each be ≥ SYNC_STAGES+1 clk cycles. Faster clocks are unsupported, and bytes may be lost.
- A command arriving when a RAMWR hi half is pending drops that half-pixel; no pix_valid is produced for it.

## Configuration
- **TFT_RX_CS_EN defined:**
  - Bytes are received only while synchronized tft_cs=0.
  - Going high clears the bit counter and discards the partial byte.
  - FSM state and the pixel half are retained across cs toggles.
- **Undefined:** tft_cs is ignored and the receiver is always selected. This matches the current top level, which ties cs to 0.

## Structure
- Package tft_pkg:
  - Command codes CMD_CASET/CMD_PASET/CMD_RAMWR.
  - Decoder state enum.
  - Default window constants.
- Sub-module spi_byte_rx: synchronizers, edge detect, shifter, cs handling. Outputs byte_valid/byte_data/byte_dc.
- The FSM and cursor live in tft_rx_decoder.

## Test plan
- After reset, send 0x2C then bytes F8,00,07,E0 → pix_valid at (0,0) data F800, then at (1,0) data 07E0.
- CASET 00,0A,00,0B; PASET 00,05,00,06; RAMWR with 5 pixels → coordinates (10,5),(11,5),(10,6),(11,6),(10,5).
- Command 0x36 followed by data 0x48 → cmd_valid with cmd_code 36, byte_valid for 48, no pix_valid, window unchanged.
- During RAMWR, send one data byte then command 0x2C → no pix_valid for the orphan byte; the next pixel lands at (win_xs,win_ys).
- Assert rst after 4 bits of a byte, release, then send full byte 0x2A → cmd_code 2A, with no corruption from the partial bits.
- TFT_RX_CS_EN: raise cs after 5 bits, lower it, send 0x2B → exactly one byte_valid, carrying 2B.
